// File: rtl/cache_ctrl_param.sv
// rtl/cache_ctrl_param.sv - parametrised direct-mapped write-through cache controller
// One-word lines, internal memory-latency counter, optional write-allocate, saturating hit/miss counters.
module cache_ctrl_param #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int INDEX_W     = 4,
  parameter int MEM_LAT     = 4,
  parameter int WRITE_ALLOC = 0,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Strobe,
  input  logic              RW,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WData,
  input  logic              flush,
  output logic              Rdy,
  output logic [DATA_W-1:0] RData,
  output logic              MStrobe,
  output logic              MRW,
  output logic [ADDR_W-1:0] MAddr,
  output logic [DATA_W-1:0] MWData,
  input  logic [DATA_W-1:0] MRData,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_REQ,
    MEM_WAIT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_hit;
  logic [LAT_W-1:0]  lat_cnt;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               lookup_hit;
  logic               accept;
  logic               mem_last;
  logic               line_we;
  logic [DATA_W-1:0]  line_wdata;

  assign req_idx    = req_addr[INDEX_W-1:0];
  assign req_tag    = req_addr[ADDR_W-1:INDEX_W];
  assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign accept     = (state == IDLE) && !flush && Strobe;
  assign mem_last   = (state == MEM_WAIT) && (lat_cnt == '0);

  // A write miss without allocation completes the memory write but leaves the array alone.
  assign line_we    = mem_last && (!req_rw || req_hit || (WRITE_ALLOC != 0));
  assign line_wdata = req_rw ? req_wdata : MRData;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    Rdy      = 1'b0;
    MStrobe  = 1'b0;
    MRW      = 1'b0;
    MAddr    = '0;
    MWData   = '0;
    if (state != IDLE) begin
      MRW    = req_rw;
      MAddr  = req_addr;
      MWData = req_wdata;
    end
    case (state)
      IDLE:     if (accept) state_nx = LOOKUP;
      LOOKUP:   state_nx = (!req_rw && lookup_hit) ? DONE : MEM_REQ;
      MEM_REQ: begin
        MStrobe  = 1'b1;
        state_nx = MEM_WAIT;
      end
      MEM_WAIT: if (lat_cnt == '0) state_nx = DONE;
      DONE: begin
        Rdy      = 1'b1;
        state_nx = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_rw    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_hit   <= 1'b0;
      lat_cnt   <= '0;
      valid     <= '0;
      RData     <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      if (state == IDLE && flush) valid <= '0;
      if (accept) begin
        req_rw    <= RW;
        req_addr  <= Addr;
        req_wdata <= WData;
      end
      if (state == LOOKUP) begin
        req_hit <= lookup_hit;
        if (lookup_hit) begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
        end else begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
        end
        if (!req_rw && lookup_hit) RData <= data_mem[req_idx];
      end
      if (state == MEM_REQ) lat_cnt <= LAT_W'(MEM_LAT - 1);
      if (state == MEM_WAIT && lat_cnt != '0) lat_cnt <= lat_cnt - LAT_W'(1);
      if (line_we) valid[req_idx] <= 1'b1;
      if (mem_last && !req_rw) RData <= MRData;
    end
  end

  // Tag and data contents need no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= line_wdata;
    end
  end

endmodule

// File: doc/cache_ctrl_param.md
# cache_ctrl_param

Parametrised direct-mapped, write-through cache controller with integrated tag/valid/data arrays, placed between the CPU request port and main memory. It generalises the fixed cache FSM in four ways: configurable address, data and index widths; a configurable memory latency counted internally; a selectable write-allocate mode; and a single-cycle flush. It also keeps saturating hit and miss counters for performance measurement.

## Interface
- ADDR_W, 16, CPU/memory address width.
- DATA_W, 16, data word width.
- INDEX_W, 4, index bits. The cache holds 2^INDEX_W one-word lines. Tag width is ADDR_W-INDEX_W.
- MEM_LAT, 4, memory latency in cycles. Must be ≥1.
- WRITE_ALLOC, 0, write-miss policy: 1 = allocate line on write miss, 0 = no allocate.
- CNT_W, 16, width of the hit and miss counters.
- clk  in  1  clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- Strobe  in  1  CPU request valid; sampled only in IDLE.
- RW  in  1  request type: 1 = write, 0 = read.
- Addr  in  ADDR_W  request address.
- WData  in  DATA_W  write data.
- flush  in  1  invalidate all lines; honoured only in IDLE.
- Rdy  out  1  one-cycle completion pulse.
- RData  out  DATA_W  read result; valid when Rdy=1 on a read, held until the next read completes.
- MStrobe  out  1  memory request; a one-cycle pulse.
- MRW  out  1  memory request type: 1 = write, 0 = read.
- MAddr  out  ADDR_W  memory address, equal to the captured Addr.
- MWData  out  DATA_W  memory write data, equal to the captured WData.
- MRData  in  DATA_W  memory read data; valid in the last MEM_WAIT cycle.
- hit_cnt  out  CNT_W  saturating hit count.
- miss_cnt  out  CNT_W  saturating miss count.

## Operation
- Address split: index = Addr[INDEX_W-1:0]; tag = Addr[ADDR_W-1:INDEX_W].
- A lookup hits when valid[index]=1 and the stored tag equals the request tag.
- States: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, DONE.
- IDLE:
  - flush=1: clear every valid bit; stay in IDLE. flush has priority over Strobe, so a simultaneous Strobe is not accepted and the CPU must keep Strobe high.
  - Otherwise Strobe=1: capture RW, Addr and WData; go to LOOKUP.
- LOOKUP:
  - Read hit: latch RData from the line; go to DONE.
  - Read miss: go to MEM_REQ.
  - Any write, hit or miss: go to MEM_REQ (write-through).
  - hit_cnt or miss_cnt increments by 1 here, saturating at all-ones.
- MEM_REQ: MStrobe=1. MRW = captured RW. The latency counter loads MEM_LAT-1. Go to MEM_WAIT.
- MEM_WAIT: the counter decrements each cycle. When the counter is 0:
  - Read: write tag, valid=1 and MRData into the line; RData = MRData.
  - Write hit: update the line data with WData.
  - Write miss with WRITE_ALLOC=1: install tag, valid=1 and WData.
  - Write miss with WRITE_ALLOC=0: leave the cache untouched.
  - Go to DONE.
- DONE: Rdy=1; go to IDLE.
- Strobe and flush are ignored in every state except IDLE.
- MAddr and MWData are driven from the captured request whenever the controller is not in IDLE; they are 0 in IDLE.
- Reset values: state IDLE, all valid bits 0, Rdy=0, MStrobe=0, MRW=0, RData=0, hit_cnt=0, miss_cnt=0. Tag and data array contents are don't-care.
- Reset asserted mid-transaction drops MStrobe immediately and abandons the memory access. No line is written.

## Timing
- Edge 0 is the edge that accepts a request. Cycle n is the period after edge n.
- Read hit: LOOKUP in cycle 0; Rdy in cycle 1.
- Read miss or any write:
  - MStrobe in cycle 1.
  - MEM_WAIT in cycles 2 to 1+MEM_LAT.
  - Rdy in cycle 2+MEM_LAT.
- Minimum request spacing: one IDLE cycle follows DONE, so the next request can be accepted at edge 2 after a hit-completion edge.
- MEM_LAT=1: MEM_WAIT lasts exactly one cycle.
- Counter saturation: at all-ones the counter holds its value; it never wraps to 0.

## Test plan
Configuration for all scenarios: defaults, MEM_LAT=4, memory returns fixed data.

1. Cold read 0x0012 with memory returning 0xBEEF:
   - MStrobe in cycle 1, MRW=0, MAddr=0x0012.
   - Rdy in cycle 6 with RData=0xBEEF; miss_cnt=1.
   - Repeat the read: Rdy in cycle 1 with 0xBEEF, no MStrobe, hit_cnt=1.
2. Conflict on index 2:
   - Read 0x0112 → miss; the line is replaced.
   - Read 0x0012 → miss again; miss_cnt increments each time.
3. Write miss to 0x0034 with data 0x1234:
   - MStrobe with MRW=1 and MWData=0x1234; Rdy in cycle 6.
   - WRITE_ALLOC=0: a following read of 0x0034 misses.
   - WRITE_ALLOC=1: a following read of 0x0034 hits with RData=0x1234 and no MStrobe.
4. Write hit after filling 0x0012:
   - Write 0x5555 → a memory write is still issued; Rdy in cycle 6.
   - Read 0x0012 → hit in cycle 1 with RData=0x5555.
5. Flush:
   - flush and Strobe high in the same IDLE cycle: the request is not accepted that cycle and is accepted on the next edge.
   - Read of the previously valid 0x0012 afterwards → miss.
6. Reset and saturation:
   - Assert reset during MEM_WAIT: MStrobe=0, state IDLE, counters 0, and a read of any earlier-filled line misses.
   - With CNT_W=2, five misses → miss_cnt=3.
